// File: rtl/prng_pkg.sv
// Shared constants, types and width helpers for the PRNG word server.
package prng_pkg;

    localparam int PRNG_W = 128;
    localparam int WORD_W = 32;

    typedef logic [PRNG_W-1:0] sample_t;
    typedef logic [WORD_W-1:0] word_t;

    function automatic int slice_count(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Counter/pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prng_sync_fifo.sv
// DEPTH x WIDTH synchronous FIFO with push/pop/flush and an occupancy count.
module prng_sync_fifo
    import prng_pkg::*;
#(
    parameter int WIDTH = PRNG_W,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_flush,
    input  logic [WIDTH-1:0]              i_wr_data,
    output logic [WIDTH-1:0]              o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [level_width(DEPTH)-1:0] o_level
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    // Flush wins over both ports; a full FIFO refuses a push even if popped this cycle.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/prng_word_server.sv
// Decimates the free-running PRNG state into a FIFO and serves it as OUT_W-bit words.
// Optional repetition/all-zero health test enabled by defining PRNG_HEALTH_TEST_EN.
module prng_word_server
    import prng_pkg::*;
#(
    parameter int IN_W      = PRNG_W,
    parameter int OUT_W     = 32,
    parameter int DEPTH     = 4,
    parameter int DECIM     = 128,
    parameter int REP_LIMIT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_W-1:0]               i_src_data,
    input  logic                          i_src_valid,
    output logic                          o_src_ready,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [OUT_W-1:0]              o_rd_data,
    output logic [level_width(DEPTH)-1:0] o_fill_level,
    output logic                          o_health_fail
);

    localparam int NSLICE = slice_count(IN_W, OUT_W);
    localparam int SL_W   = clog2_min1(NSLICE);
    localparam int CNT_W  = clog2_min1(DECIM);

    if (IN_W % OUT_W != 0) begin : g_bad_width
        $error("IN_W must be a multiple of OUT_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (DECIM < 1 || REP_LIMIT < 2) begin : g_bad_rate
        $error("DECIM must be >= 1 and REP_LIMIT >= 2");
    end

    logic [CNT_W-1:0] r_decim_cnt;
    logic [SL_W-1:0]  r_slice;
    logic             w_sample;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_health_fail;
    logic             w_full;
    logic             w_empty;
    logic             w_hs;
    logic             w_last_slice;
    logic [IN_W-1:0]  w_head;

    // The wrap cycle of the decimation counter is the sample point.
    assign w_sample = i_src_valid && (r_decim_cnt == CNT_W'(DECIM - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decim_cnt <= '0;
        end else if (i_src_valid) begin
            r_decim_cnt <= w_sample ? '0 : r_decim_cnt + CNT_W'(1);
        end
    end

`ifdef PRNG_HEALTH_TEST_EN
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    logic [IN_W-1:0]  r_prev_sample;
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_health_fail;
    logic [REP_W-1:0] w_rep_next;
    logic             w_fail_now;

    always_comb begin
        w_rep_next = REP_W'(1);
        if (i_src_data == r_prev_sample) begin
            w_rep_next = (r_rep_cnt == REP_W'(REP_LIMIT)) ? r_rep_cnt : r_rep_cnt + REP_W'(1);
        end
    end

    // Dropped samples are tested too, so this does not look at FIFO space.
    assign w_fail_now = w_sample && ((w_rep_next >= REP_W'(REP_LIMIT)) || (i_src_data == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_sample <= '0;
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else begin
            if (w_sample) begin
                r_prev_sample <= i_src_data;
                r_rep_cnt     <= w_rep_next;
            end
            if (w_fail_now) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    // Flush on the failing edge so the FIFO is empty when health_fail first shows.
    assign w_health_fail = r_health_fail;
    assign w_flush       = w_fail_now || r_health_fail;
`else
    assign w_health_fail = 1'b0;
    assign w_flush       = 1'b0;
`endif

    assign w_push = w_sample && !w_full && !w_health_fail;

    prng_sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data (i_src_data),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_fill_level)
    );

    assign o_rd_valid   = !w_empty && !w_health_fail;
    assign w_hs         = o_rd_valid && i_rd_ready;
    assign w_last_slice = (r_slice == SL_W'(NSLICE - 1));
    assign w_pop        = w_hs && w_last_slice;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slice <= '0;
        end else if (w_flush) begin
            r_slice <= '0;
        end else if (w_hs) begin
            r_slice <= w_last_slice ? '0 : r_slice + SL_W'(1);
        end
    end

    assign o_rd_data     = w_head[int'(r_slice) * OUT_W +: OUT_W];
    assign o_src_ready   = !w_full;
    assign o_health_fail = w_health_fail;

endmodule

// File: tb/tb_prng_word_server.sv
// Directed bench for prng_word_server with DECIM=4, DEPTH=4, 128-bit samples, 32-bit words.
module tb_prng_word_server;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] i_src_data = '0;
    logic         i_src_valid = 1'b0;
    logic         o_src_ready;
    logic         o_rd_valid;
    logic         i_rd_ready = 1'b0;
    logic [31:0]  o_rd_data;
    logic [2:0]   o_fill_level;
    logic         o_health_fail;

    int n_chk = 0;
    int n_pass = 0;
    int k = 0;

    prng_word_server #(
        .IN_W(128), .OUT_W(32), .DEPTH(4), .DECIM(4), .REP_LIMIT(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_src_data    (i_src_data),
        .i_src_valid   (i_src_valid),
        .o_src_ready   (o_src_ready),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_rd_data     (o_rd_data),
        .o_fill_level  (o_fill_level),
        .o_health_fail (o_health_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [2:0]  exp_fill;
        logic        exp_src_ready;
    } vec_t;

    vec_t vec[12];

    // Slice j of the sample taken on cycle c carries c+j, so order is visible.
    function automatic logic [127:0] mk(input int c);
        return {32'(c + 3), 32'(c + 2), 32'(c + 1), 32'(c)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (k=%0d): got %0h expected %0h", nm, k, act, exp);
    endtask

    task automatic tick(input logic [127:0] d);
        i_src_data = d;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_src_valid = 1'b1;
        i_rd_ready = 1'b0;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
    endtask

    logic [127:0] pat;
    logic [31:0]  held;
    logic [31:0]  base;
    logic [31:0]  bases [4];
    int           slc;
    int           n_words;
    logic         stalled;

    initial begin
        // k: rd_ready, rd_valid, rd_data, fill, src_ready after edge k
        vec[0]  = '{1'b1, 1'b0, 32'd0,  3'd0, 1'b1};
        vec[1]  = '{1'b1, 1'b0, 32'd0,  3'd0, 1'b1};
        vec[2]  = '{1'b1, 1'b0, 32'd0,  3'd0, 1'b1};
        vec[3]  = '{1'b1, 1'b1, 32'd3,  3'd1, 1'b1};
        vec[4]  = '{1'b1, 1'b1, 32'd4,  3'd1, 1'b1};
        vec[5]  = '{1'b1, 1'b1, 32'd5,  3'd1, 1'b1};
        vec[6]  = '{1'b1, 1'b1, 32'd6,  3'd1, 1'b1};
        vec[7]  = '{1'b1, 1'b1, 32'd7,  3'd1, 1'b1};
        vec[8]  = '{1'b1, 1'b1, 32'd8,  3'd1, 1'b1};
        vec[9]  = '{1'b1, 1'b1, 32'd9,  3'd1, 1'b1};
        vec[10] = '{1'b1, 1'b1, 32'd10, 3'd1, 1'b1};
        vec[11] = '{1'b1, 1'b1, 32'd11, 3'd1, 1'b1};
        bases = '{32'd7, 32'd11, 32'd15, 32'd31};

        // Reset state
        #2;
        chk("rst_rd_valid", 128'(o_rd_valid), 128'd0);
        chk("rst_rd_data", 128'(o_rd_data), 128'd0);
        chk("rst_fill", 128'(o_fill_level), 128'd0);
        chk("rst_src_ready", 128'(o_src_ready), 128'd1);
        chk("rst_health", 128'(o_health_fail), 128'd0);

        // Decimation and LSB-first serialization
        do_reset();
        for (int i = 0; i < 12; i++) begin
            i_rd_ready = vec[i].rd_ready;
            tick(mk(k));
            chk("t1_valid", 128'(o_rd_valid), 128'(vec[i].exp_valid));
            chk("t1_data", 128'(o_rd_data), 128'(vec[i].exp_data));
            chk("t1_fill", 128'(o_fill_level), 128'(vec[i].exp_fill));
            chk("t1_src_ready", 128'(o_src_ready), 128'(vec[i].exp_src_ready));
        end

        // Fill, drop while full, then verify fresh sample after space frees
        do_reset();
        for (int i = 0; i < 24; i++) tick(mk(k));
        chk("t2_full_fill", 128'(o_fill_level), 128'd4);
        chk("t2_full_src_ready", 128'(o_src_ready), 128'd0);
        chk("t2_full_head", 128'(o_rd_data), 128'd3);
        i_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(mk(k));
        chk("t2_pop_fill", 128'(o_fill_level), 128'd3);
        chk("t2_pop_head", 128'(o_rd_data), 128'd7);
        i_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick(mk(k));
        chk("t2_refill", 128'(o_fill_level), 128'd4);
        i_rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_valid", 128'(o_rd_valid), 128'd1);
            chk("t2_drain_data", 128'(o_rd_data), 128'(bases[i / 4] + 32'(i % 4)));
            tick(mk(k));
        end

        // Toggling rd_ready: stable on stall, each slice once, in order
        do_reset();
        slc = 0;
        base = '0;
        n_words = 0;
        for (int i = 0; i < 96; i++) begin
            i_rd_ready = (i % 2 == 1);
            stalled = o_rd_valid && !i_rd_ready;
            held = o_rd_data;
            if (o_rd_valid && i_rd_ready) begin
                n_words++;
                if (slc == 0) begin
                    chk("t3_base_phase", 128'(o_rd_data % 4), 128'd3);
                    chk("t3_base_order", 128'(o_rd_data > base), 128'd1);
                    base = o_rd_data;
                end else begin
                    chk("t3_slice_order", 128'(o_rd_data), 128'(base + 32'(slc)));
                end
                slc = (slc + 1) % 4;
            end
            tick(mk(k));
            if (stalled) chk("t3_stall_stable", 128'(o_rd_data), 128'(held));
        end
        chk("t3_word_count", 128'(n_words >= 40), 128'd1);

        // Reset after two slices of the head are served
        do_reset();
        i_rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick(mk(k));
        chk("t5_pre_data", 128'(o_rd_data), 128'd5);
        reset = 1'b1;
        #2;
        chk("t5_rst_valid", 128'(o_rd_valid), 128'd0);
        chk("t5_rst_data", 128'(o_rd_data), 128'd0);
        chk("t5_rst_fill", 128'(o_fill_level), 128'd0);
        chk("t5_rst_src_ready", 128'(o_src_ready), 128'd1);
        chk("t5_rst_health", 128'(o_health_fail), 128'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) tick(mk(k));
        chk("t5_restart_early", 128'(o_fill_level), 128'd0);
        tick(mk(k));
        chk("t5_restart_fill", 128'(o_fill_level), 128'd1);
        chk("t5_restart_data", 128'(o_rd_data), 128'd3);

        pat = {16{8'hA5}};
`ifdef PRNG_HEALTH_TEST_EN
        // Repetition failure on the third identical sample
        do_reset();
        for (int i = 0; i < 11; i++) tick(pat);
        chk("t4_pre_fill", 128'(o_fill_level), 128'd2);
        chk("t4_pre_health", 128'(o_health_fail), 128'd0);
        tick(pat);
        chk("t4_rep_health", 128'(o_health_fail), 128'd1);
        chk("t4_rep_valid", 128'(o_rd_valid), 128'd0);
        chk("t4_rep_fill", 128'(o_fill_level), 128'd0);
        for (int i = 0; i < 8; i++) tick(mk(k + 1));
        chk("t4_sticky_health", 128'(o_health_fail), 128'd1);
        chk("t4_blocked_fill", 128'(o_fill_level), 128'd0);
        // All-zero sample fails on its own
        do_reset();
        for (int i = 0; i < 3; i++) tick(128'd0);
        chk("t4_zero_pre", 128'(o_health_fail), 128'd0);
        tick(128'd0);
        chk("t4_zero_health", 128'(o_health_fail), 128'd1);
        chk("t4_zero_fill", 128'(o_fill_level), 128'd0);
`else
        // Without the health test, constant data is served continuously
        do_reset();
        i_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick(pat);
        for (int i = 0; i < 36; i++) begin
            chk("t6_valid", 128'(o_rd_valid), 128'd1);
            chk("t6_data", 128'(o_rd_data), 128'h0000_0000_0000_0000_0000_0000_A5A5_A5A5);
            tick(pat);
        end
        chk("t6_health", 128'(o_health_fail), 128'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
